simon_button_conditioner: RTL

Upstream input stage for simon_game. It takes the four raw player buttons and produces clean debounced levels plus one press event per debounced rising edge. Debounce timing is in milliseconds, derived from the same ticks_per_ms value the game uses. Pending presses are held in a per-button mask and handed to the game one at a time over a valid/ready handshake.

---
 rtl/simon_button_conditioner.sv | 130 +++++++++++++
 1 files changed

// File: rtl/simon_button_conditioner.sv
// Button front end for simon_game: synchronize, debounce in ms, queue presses.
// Presses are handed out lowest index first over a valid/ready handshake.
module simon_button_conditioner #(
  parameter int DEBOUNCE_MS = 10,
  parameter int NUM_BTN     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        ticks_per_ms,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               flush,
  output logic [NUM_BTN-1:0] btn_level,
  output logic               press_valid,
  output logic [1:0]         press_idx,
  input  logic               press_ready,
  output logic               overrun
);

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_MS);

  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  logic [15:0] pre_q;
  logic [15:0] pre_d;
  logic [15:0] tpm_m1;
  logic        ms_tick;

  logic [7:0]         cnt_q [NUM_BTN];
  logic [7:0]         cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q;
  logic [NUM_BTN-1:0] level_d;

  logic [NUM_BTN-1:0] pend_q;
  logic [NUM_BTN-1:0] pend_d;
  logic               ovr_q;
  logic               ovr_d;

  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] acc;
  logic [1:0]         idx;

  // ticks_per_ms of 0 behaves as 1, so the terminal count is 0
  always_comb begin
    tpm_m1 = 16'd0;
    if (ticks_per_ms != 16'd0) begin
      tpm_m1 = ticks_per_ms - 16'd1;
    end
    ms_tick = (pre_q >= tpm_m1);
    pre_d   = ms_tick ? 16'd0 : pre_q + 16'd1;
  end

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i]   = cnt_q[i];
      level_d[i] = level_q[i];
      if (sync2_q[i] == level_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (ms_tick) begin
        if (cnt_q[i] + 8'd1 == DEB_LIM) begin
          level_d[i] = sync2_q[i];
          cnt_d[i]   = 8'd0;
        end else begin
          cnt_d[i] = cnt_q[i] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    idx = 2'd0;
    priority case (1'b1)
      pend_q[0]: idx = 2'd0;
      pend_q[1]: idx = 2'd1;
      pend_q[2]: idx = 2'd2;
      pend_q[3]: idx = 2'd3;
      default:   idx = 2'd0;
    endcase
  end

  // an accept and a same-button rise leave the bit set without overrun
  always_comb begin
    rise   = level_d & ~level_q;
    acc    = '0;
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (|pend_q && press_ready) begin
      acc[idx] = 1'b1;
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      pend_d[i] = (pend_q[i] & ~acc[i]) | rise[i];
      if (rise[i] && pend_q[i] && !acc[i]) begin
        ovr_d = 1'b1;
      end
    end
    if (flush) begin
      pend_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pre_q   <= 16'd0;
      level_q <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      pre_q   <= pre_d;
      level_q <= level_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign press_valid = |pend_q;
  assign press_idx   = idx;
  assign overrun     = ovr_q;

endmodule
